// File: rtl/series_ctrl_p.sv
// series_ctrl_p: Moore controller sequencing the series datapath (init, per-term multiply/accumulate/check, result load, done pulse).
//   Optional macro EARLY_EXIT_EN: when defined, lt=1 in CHECK ends the run early.
//   i_clk      rising-edge clock           i_rst      asynchronous active-low reset
//   i_start    begin request (edge-qualified via ARMED)
//   i_lt       term below convergence threshold (used only with EARLY_EXIT_EN)
//   i_n_terms  terms to evaluate, sampled in INIT, 0 treated as 1
//   o_initt/o_initr/o_initc  clear t, r and datapath counter     o_ready  idle, accepting start
//   o_ld_x/o_ld_y/o_ld_r/o_ld_t  register loads   o_cnt  bump datapath counter
//   o_sel      mux select: 0 INIT, 1 MUL, 2 ADD, 3 OUT            o_mode  0 add, 1 subtract
//   o_done     one-cycle completion pulse  o_term_idx  terms completed so far
module series_ctrl_p #(
  parameter int CNT_W    = 4,
  parameter int SEL_W    = 3,
  parameter int ALT_SIGN = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_lt,
  input  logic [CNT_W-1:0] i_n_terms,
  output logic             o_initt,
  output logic             o_initr,
  output logic             o_initc,
  output logic             o_ready,
  output logic             o_ld_x,
  output logic             o_ld_y,
  output logic             o_ld_r,
  output logic             o_ld_t,
  output logic             o_cnt,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_mode,
  output logic             o_done,
  output logic [CNT_W-1:0] o_term_idx
);
  typedef enum logic [2:0] {IDLE, ARMED, INIT, MUL, ACC, CHECK, OUT, DONE} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, r_n_eff;
  logic             w_exit;
`ifdef EARLY_EXIT_EN
  assign w_exit = (r_cnt == r_n_eff) || i_lt;
`else
  logic w_unused_lt;
  assign w_unused_lt = i_lt;
  assign w_exit = r_cnt == r_n_eff;
`endif
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_n_eff <= CNT_W'(1);
    end else begin
      r_state <= w_next;
      if (r_state == INIT) begin
        r_cnt   <= '0;
        r_n_eff <= (i_n_terms == '0) ? CNT_W'(1) : i_n_terms;
      end else if (r_state == ACC)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? ARMED : IDLE;
      ARMED:   w_next = i_start ? ARMED : INIT;
      INIT:    w_next = MUL;
      MUL:     w_next = ACC;
      ACC:     w_next = CHECK;
      CHECK:   w_next = w_exit ? OUT : MUL;
      OUT:     w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    o_ready    = r_state == IDLE;
    o_initt    = r_state == INIT;
    o_initr    = r_state == INIT;
    o_initc    = r_state == INIT;
    o_ld_x     = r_state == INIT;
    o_ld_t     = r_state == MUL;
    o_ld_r     = r_state == ACC;
    o_cnt      = r_state == ACC;
    o_ld_y     = r_state == OUT;
    o_done     = r_state == DONE;
    // The counter still holds the index of the term being accumulated, so bit 0 gives the sign.
    o_mode     = (r_state == ACC) && (ALT_SIGN != 0) && r_cnt[0];
    o_sel      = (r_state == MUL)                       ? SEL_W'(1) :
                 (r_state == ACC || r_state == CHECK)   ? SEL_W'(2) :
                 (r_state == OUT)                       ? SEL_W'(3) : '0;
    o_term_idx = r_cnt;
  end
endmodule

// File: tb/tb_series_ctrl_p.sv
module tb_series_ctrl_p;
  logic       clk = 0, rst_n = 0, start = 0, lt = 0;
  logic [3:0] n_terms = 0;
  logic       o_initt, o_initr, o_initc, o_ready, o_ld_x, o_ld_y, o_ld_r, o_ld_t, o_cnt, o_mode, o_done;
  logic [2:0] o_sel;
  logic [3:0] o_term_idx;
  int         n_chk = 0, n_err = 0;

  series_ctrl_p dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_lt(lt), .i_n_terms(n_terms),
    .o_initt(o_initt), .o_initr(o_initr), .o_initc(o_initc), .o_ready(o_ready),
    .o_ld_x(o_ld_x), .o_ld_y(o_ld_y), .o_ld_r(o_ld_r), .o_ld_t(o_ld_t), .o_cnt(o_cnt),
    .o_sel(o_sel), .o_mode(o_mode), .o_done(o_done), .o_term_idx(o_term_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses start, follows one run and checks its shape. Span is counted inclusively
  // from the INIT cycle to the done cycle. rehold raises start again from INIT onward.
  task automatic run(input string tag, input logic [3:0] nt, input int exp_terms, input bit early, input bit rehold);
    int         t_init = -1, t_done = -1, n_init = 0, n_acc = 0, n_y = 0, n_x = 0;
    logic [15:0] modes = '0;
    bit         fin = 0;
    n_terms = nt;
    lt = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (t_done >= 0) begin
        chk({tag, " ready after done"}, int'(o_ready), 1);
        chk({tag, " done one cycle"}, int'(o_done), 0);
        fin = 1;
      end else begin
        if (o_initt) begin
          n_init++;
          t_init = c;
          if (rehold) start = 1;
        end
        if (o_ld_x) n_x++;
        if (o_ld_r) begin
          if (n_acc < 16) modes[n_acc] = o_mode;
          n_acc++;
        end
        if (o_ld_y) n_y++;
        if (o_done) t_done = c;
        lt = early && (o_term_idx >= 4'd3);
      end
    end
    chk({tag, " run finished"}, int'(fin), 1);
    chk({tag, " init count"}, n_init, 1);
    chk({tag, " ld_x count"}, n_x, 1);
    chk({tag, " acc count"}, n_acc, exp_terms);
    chk({tag, " acc modes"}, int'(modes), int'(16'hAAAA) & ((1 << exp_terms) - 1));
    chk({tag, " ld_y count"}, n_y, 1);
    chk({tag, " span"}, t_done - t_init + 1, 3 + 3 * exp_terms);
    chk({tag, " term_idx"}, int'(o_term_idx), exp_terms);
    lt = 0;
  endtask

  initial begin
    int cnt_i, acc;
    // reset
    repeat (2) @(negedge clk);
    chk("rst ready", int'(o_ready), 1);
    chk("rst sel", int'(o_sel), 0);
    chk("rst done", int'(o_done), 0);
    chk("rst term_idx", int'(o_term_idx), 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("idle stays ready", int'(o_ready), 1);
    chk("idle no init", int'(o_initt), 0);

    run("n3", 4'd3, 3, 0, 0);
    run("n0", 4'd0, 1, 0, 0);

    // start held high: nothing begins until release
    n_terms = 4'd2;
    start = 1;
    cnt_i = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_initt) cnt_i++;
    end
    chk("held no init", cnt_i, 0);
    chk("held armed not ready", int'(o_ready), 0);
    run("held", 4'd2, 2, 0, 1);
    cnt_i = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_initt) cnt_i++;
    end
    chk("rehold no retrigger", cnt_i, 0);
    start = 0;
    cnt_i = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_initt) cnt_i++;
    end
    chk("release retriggers", cnt_i, 1);
    repeat (12) @(negedge clk);
    chk("retrigger run idle", int'(o_ready), 1);

    // reset during the second ACC of a 5-term run
    n_terms = 4'd5;
    start = 1;
    @(negedge clk);
    start = 0;
    acc = 0;
    for (int c = 0; c < 50 && acc < 2; c++) begin
      @(negedge clk);
      if (o_ld_r) acc++;
    end
    chk("reached second acc", acc, 2);
    #1 rst_n = 0;
    #1;
    chk("midrst ready", int'(o_ready), 1);
    chk("midrst sel", int'(o_sel), 0);
    chk("midrst ld_r", int'(o_ld_r), 0);
    chk("midrst term_idx", int'(o_term_idx), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    cnt_i = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_done) cnt_i++;
    end
    chk("midrst no done", cnt_i, 0);
    run("after rst", 4'd2, 2, 0, 0);

`ifdef EARLY_EXIT_EN
    run("early", 4'd8, 3, 1, 0);
`else
    run("no early", 4'd8, 8, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/series_ctrl_p.md
Name: series_ctrl_p

Overview:
- Parametrised successor to the iterative series-evaluation controller.
- Sequences the datapath through init, per-term multiply, signed accumulate and convergence check, then result load.
- Generalises the fixed s2/s1/s0 select lines into a SEL_W bus and the fixed term count into a runtime, parameter-bounded count.
- Adds alternating-sign accumulation and a done pulse. Sits between the top-level handshake and the series datapath (x/y/r/t registers, term counter, comparator producing lt).

Parameters:
- CNT_W, 4: width of the term counter, n_terms and term_idx; max terms 2^CNT_W-1.
- SEL_W, 3: width of the datapath mux select bus; must be >= 2.
- ALT_SIGN, 1: 1 = mode alternates add/sub per term; 0 = mode always 0 (add).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin request; level, edge-qualified (see Behaviour).
- lt  in  1  datapath comparator: current term below convergence threshold.
- n_terms  in  CNT_W  terms to evaluate; sampled in INIT; 0 treated as 1.
- initt  out  1  clear term register t.
- initr  out  1  clear result register r.
- initc  out  1  clear datapath term counter.
- ready  out  1  idle, accepting start.
- ld_x  out  1  load operand register x.
- ld_y  out  1  load output register y.
- ld_r  out  1  load result register r.
- ld_t  out  1  load term register t.
- cnt  out  1  increment datapath term counter.
- sel  out  SEL_W  datapath mux select: 0 INIT, 1 MUL, 2 ADD, 3 OUT; other codes unused.
- mode  out  1  adder mode: 0 add, 1 subtract.
- done  out  1  one-cycle completion pulse.
- term_idx  out  CNT_W  terms completed so far.

Behaviour:
- Moore FSM. All outputs are decoded from the registered state and the internal counter; no combinational input-to-output paths.
- States and transitions:
  - IDLE: ready=1, sel=0. start=1 -> ARMED.
  - ARMED: ready=0. Waits for start=0 -> INIT. Each run starts once per start pulse.
  - INIT: initt=initr=initc=1, ld_x=1, sel=0. Clears the internal counter and latches n_eff = max(n_terms,1). -> MUL.
  - MUL: ld_t=1, sel=1. -> ACC.
  - ACC: ld_r=1, cnt=1, sel=2, mode = ALT_SIGN ? counter[0] : 0. Counter increments at the end of the cycle. -> CHECK.
  - CHECK: sel=2. If counter==n_eff -> OUT; otherwise -> MUL.
  - OUT: ld_y=1, sel=3. -> DONE.
  - DONE: done=1. -> IDLE.
- Every output not listed for a state is 0.
- Latency with no early exit: from the first cycle in INIT to the done pulse = 3 + 3·n_eff cycles.
- term_idx = internal counter. Reset value 0. Holds its last value through IDLE until the next INIT. Never wraps, because n_eff <= 2^CNT_W-1.
- start is ignored in every state except IDLE and ARMED. start held high through DONE does not retrigger: IDLE then ARMED, and the run waits for release.
- n_terms changes after INIT have no effect until the next run.
- Reset (rst=0), asynchronous and at any time including mid-run:
  - state -> IDLE, counter -> 0, n_eff -> 1.
  - Outputs during and after reset: ready=1, sel=0, all other outputs 0.
  - No done pulse is generated for an aborted run.

Optional Feature:
- Macro EARLY_EXIT_EN.
- Defined: in CHECK, lt=1 -> OUT regardless of the counter. term_idx then reports the terms actually used.
- Undefined: lt is ignored; the run always takes n_eff terms. The port remains, unused.

Test Plan:
- Reset: rst=0 for 2 cycles -> ready=1, sel=0, done=0, term_idx=0. rst=1 with start=0 -> remains IDLE.
- n_terms=3, start pulsed high 1 cycle, lt=0 -> INIT once. Then the MUL/ACC/CHECK sequence runs 3 times, with mode 0,1,0 on ACC cycles. ld_y in OUT, done high exactly 1 cycle 12 cycles after INIT, term_idx=3, ready=1 next cycle.
- n_terms=0 -> runs as 1 term: done 6 cycles after INIT, term_idx=1.
- start held high for 20 cycles with n_terms=2 -> run does not begin until start falls. Holding start through DONE gives no second run until start falls again.
- Mid-run reset: rst=0 asserted during the second ACC of a 5-term run -> immediate IDLE, ready=1, no done. A new start runs cleanly from term_idx 0.
- EARLY_EXIT_EN defined, n_terms=8, lt=1 from the 3rd CHECK -> OUT after 3 terms, term_idx=3. Macro undefined with the same stimulus -> 8 terms, term_idx=8.
